// File: rtl/ttt_defs_pkg.sv
// Shared encodings for the tic-tac-toe sequencer: FSM states, ASCII status
// bytes and the eight winning line masks.
package ttt_defs;

    localparam logic [2:0] S_TURN_X = 3'd0;
    localparam logic [2:0] S_TURN_O = 3'd1;
    localparam logic [2:0] S_CHECK  = 3'd2;
    localparam logic [2:0] S_WIN_X  = 3'd3;
    localparam logic [2:0] S_WIN_O  = 3'd4;
    localparam logic [2:0] S_CATS   = 3'd5;
    localparam logic [2:0] S_ERROR  = 3'd6;

    localparam logic [7:0] ST_PLAY = 8'h2D;
    localparam logic [7:0] ST_WINX = 8'h58;
    localparam logic [7:0] ST_WINO = 8'h4F;
    localparam logic [7:0] ST_CATS = 8'h43;
    localparam logic [7:0] ST_ERR  = 8'h45;

    localparam int N_LINES = 8;

    // Squares 852, 741, 630, 876, 543, 210, 840, 642
    localparam logic [N_LINES-1:0][8:0] WIN_LINES = {
        9'h124, 9'h092, 9'h049, 9'h1C0, 9'h038, 9'h007, 9'h111, 9'h054
    };

    function automatic logic is_onehot9(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    function automatic logic [7:0] state_ascii(input logic [2:0] s);
        case (s)
            S_WIN_X: return ST_WINX;
            S_WIN_O: return ST_WINO;
            S_CATS:  return ST_CATS;
            S_ERROR: return ST_ERR;
            default: return ST_PLAY;
        endcase
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational line/full detection on the registered board.
module win_detect
    import ttt_defs::*;
(
    input  logic [8:0] occ,
    input  logic [8:0] owner,
    output logic       x_win,
    output logic       o_win,
    output logic       full
);

    logic [8:0] x_sq;
    logic [8:0] o_sq;

    assign x_sq = occ & ~owner;
    assign o_sq = occ & owner;
    assign full = &occ;

    always_comb begin
        x_win = 1'b0;
        o_win = 1'b0;
        for (int i = 0; i < N_LINES; i++) begin
            if ((x_sq & WIN_LINES[i]) == WIN_LINES[i]) x_win = 1'b1;
            if ((o_sq & WIN_LINES[i]) == WIN_LINES[i]) o_win = 1'b1;
        end
    end

endmodule

// File: rtl/ttt_turn_sequencer.sv
// Tic-tac-toe game sequencer: button sync/edge detect, move validation,
// board registers and turn FSM driving the LEDs and the ASCII status byte.
//
//  state    | meaning
//  TURN_X   | waiting for an X move
//  TURN_O   | waiting for an O move
//  CHECK    | one cycle: evaluate the board just written
//  WIN_X    | X completed a line (terminal)
//  WIN_O    | O completed a line (terminal)
//  CATS     | board full, no line (terminal)
//  ERROR    | illegal move attempted (terminal)
module ttt_turn_sequencer
    import ttt_defs::*;
#(
    parameter int   SYNC_STAGES  = 2,
    parameter logic FIRST_PLAYER = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flash_clk,
    input  logic       buttonX,
    input  logic       buttonO,
    input  logic [8:0] sel_pos,
    output logic       turnX,
    output logic       turnO,
    output logic [8:0] occ_pos,
    output logic [7:0] game_st
);

    localparam logic [2:0] S_START = FIRST_PLAYER ? S_TURN_O : S_TURN_X;

    logic [SYNC_STAGES-1:0] sync_x;
    logic [SYNC_STAGES-1:0] sync_o;
    logic                   lvl_x_d;
    logic                   lvl_o_d;
    logic                   px;
    logic                   po;
    logic [1:0]             flash_sync;
    logic [8:0]             occ;
    logic [8:0]             owner;
    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic                   last_o;
    logic                   mover_o;
    logic                   move_ok;
    logic                   x_win;
    logic                   o_win;
    logic                   full;

    assign px = sync_x[SYNC_STAGES-1] & ~lvl_x_d;
    assign po = sync_o[SYNC_STAGES-1] & ~lvl_o_d;

    win_detect u_win_detect (
        .occ   (occ),
        .owner (owner),
        .x_win (x_win),
        .o_win (o_win),
        .full  (full)
    );

    always_comb begin
        state_nxt = state;
        move_ok   = 1'b0;
        mover_o   = (state == S_TURN_O);
        case (state)
            S_TURN_X, S_TURN_O: begin
                if (px | po) begin
                    move_ok   = (mover_o ? (po & ~px) : (px & ~po))
                              & is_onehot9(sel_pos)
                              & ~|(occ & sel_pos);
                    state_nxt = move_ok ? S_CHECK : S_ERROR;
                end
            end
            S_CHECK: begin
                if (x_win)      state_nxt = S_WIN_X;
                else if (o_win) state_nxt = S_WIN_O;
                else if (full)  state_nxt = S_CATS;
                else            state_nxt = last_o ? S_TURN_X : S_TURN_O;
            end
            default: state_nxt = state;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_x     <= '0;
            sync_o     <= '0;
            lvl_x_d    <= 1'b0;
            lvl_o_d    <= 1'b0;
            flash_sync <= 2'b00;
        end else begin
            sync_x     <= {sync_x[SYNC_STAGES-2:0], buttonX};
            sync_o     <= {sync_o[SYNC_STAGES-2:0], buttonO};
            lvl_x_d    <= sync_x[SYNC_STAGES-1];
            lvl_o_d    <= sync_o[SYNC_STAGES-1];
            flash_sync <= {flash_sync[0], flash_clk};
        end
    end

    // Outputs are registered from the next state so they change with state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= S_START;
            occ     <= 9'h000;
            owner   <= 9'h000;
            last_o  <= 1'b0;
            turnX   <= ~FIRST_PLAYER;
            turnO   <= FIRST_PLAYER;
            game_st <= ST_PLAY;
        end else begin
            state   <= state_nxt;
            turnX   <= (state_nxt == S_TURN_X);
            turnO   <= (state_nxt == S_TURN_O);
            game_st <= state_ascii(state_nxt);
            if (move_ok) begin
                occ    <= occ | sel_pos;
                owner  <= owner | (mover_o ? sel_pos : 9'h000);
                last_o <= mover_o;
            end
        end
    end

    assign occ_pos = occ & (~owner | {9{flash_sync[1]}});

endmodule

// File: tb/tb_ttt_turn_sequencer.sv
// Randomized and directed game sequences checked every cycle against a
// square-and-line board model of the game rules.
module tb_ttt_turn_sequencer;

    localparam int S = 2;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       flash_clk = 1'b0;
    logic       buttonX   = 1'b0;
    logic       buttonO   = 1'b0;
    logic [8:0] sel_pos   = 9'h000;
    logic       turnX;
    logic       turnO;
    logic [8:0] occ_pos;
    logic [7:0] game_st;

    int n_checks = 0;
    int n_errors = 0;

    ttt_turn_sequencer #(.SYNC_STAGES(S), .FIRST_PLAYER(1'b0)) dut (
        .clk       (clk),
        .reset     (reset),
        .flash_clk (flash_clk),
        .buttonX   (buttonX),
        .buttonO   (buttonO),
        .sel_pos   (sel_pos),
        .turnX     (turnX),
        .turnO     (turnO),
        .occ_pos   (occ_pos),
        .game_st   (game_st)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (7) @(posedge clk);
            #1 flash_clk = ~flash_clk;
        end
    end

    // Blink reference as seen by the design: flash_clk two clocks late.
    logic [1:0] fl_hist;
    always @(posedge clk or negedge reset) begin
        if (!reset) fl_hist <= 2'b00;
        else        fl_hist <= {fl_hist[0], flash_clk};
    end

    // Game model: board as X/O square sets, status byte, whose move.
    logic [8:0] m_x, m_o;
    logic [7:0] m_status;
    int         m_to_move;
    bit         m_pending;
    bit         chk_en = 1'b0;
    int         lines [8][3] = '{'{8,5,2}, '{7,4,1}, '{6,3,0}, '{8,7,6},
                                 '{5,4,3}, '{2,1,0}, '{8,4,0}, '{6,4,2}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            if (n_errors < 30)
                $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit model_win(input logic [8:0] b);
        for (int l = 0; l < 8; l++)
            if (b[lines[l][0]] && b[lines[l][1]] && b[lines[l][2]]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_x       = 9'h000;
        m_o       = 9'h000;
        m_status  = 8'h2D;
        m_to_move = 0;
        m_pending = 1'b0;
    endtask

    task automatic model_apply(input logic bx, input logic bo, input logic [8:0] sel);
        bit legal;
        if (m_status != 8'h2D || m_pending || !(bx || bo)) return;
        legal = ((m_to_move == 0) ? (bx && !bo) : (bo && !bx))
              && ($countones(sel) == 1) && (((m_x | m_o) & sel) == 9'h000);
        if (legal) begin
            if (m_to_move == 0) m_x = m_x | sel;
            else                m_o = m_o | sel;
            m_pending = 1'b1;
        end else begin
            m_status = 8'h45;
        end
    endtask

    task automatic model_resolve();
        if (!m_pending) return;
        m_pending = 1'b0;
        if (model_win(m_x))                 m_status = 8'h58;
        else if (model_win(m_o))            m_status = 8'h4F;
        else if ((m_x | m_o) == 9'h1FF)     m_status = 8'h43;
        else                                m_to_move = 1 - m_to_move;
    endtask

    function automatic logic [8:0] exp_occ();
        logic [8:0] e;
        for (int i = 0; i < 9; i++) e[i] = m_x[i] | (m_o[i] & fl_hist[1]);
        return e;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("turnX",   32'(turnX),   32'(m_status == 8'h2D && !m_pending && m_to_move == 0));
            check("turnO",   32'(turnO),   32'(m_status == 8'h2D && !m_pending && m_to_move == 1));
            check("game_st", 32'(game_st), 32'(m_status));
            check("occ_pos", 32'(occ_pos), 32'(exp_occ()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raise buttons just after an edge; move lands S+1 edges later, resolves at S+2.
    task automatic press(input logic bx, input logic bo, input logic [8:0] sel,
                         input int hold, input bit late_o);
        int h;
        h = (hold < S + 2) ? S + 2 : hold;
        sel_pos = sel;
        buttonX = bx;
        buttonO = bo & ~late_o;
        for (int c = 1; c <= h; c++) begin
            step();
            if (late_o && c == 1) buttonO = 1'b1;
            if (c == S + 1) model_apply(bx, bo & ~late_o, sel);
            if (c == S + 2) model_resolve();
        end
        buttonX = 1'b0;
        buttonO = 1'b0;
        repeat (S + 2) step();
    endtask

    task automatic mv(input int player, input int sq);
        press(player == 0, player == 1, 9'(1 << sq), S + 2, 1'b0);
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #1;
        check("rst_occ",   32'(occ_pos), 32'h000);
        check("rst_gst",   32'(game_st), 32'h2D);
        check("rst_turnX", 32'(turnX),   32'h1);
        check("rst_turnO", 32'(turnO),   32'h0);
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        step();
        do_reset();

        // X completes 642
        mv(0, 4); mv(1, 0); mv(0, 2); mv(1, 8); mv(0, 6);
        check("t1_gst",   32'(game_st), 32'h58);
        check("t1_turns", 32'({turnX, turnO}), 32'h0);
        check("t1_xsq",   32'(occ_pos & 9'h054), 32'h054);
        check("t1_osq",   32'(occ_pos & 9'h101), fl_hist[1] ? 32'h101 : 32'h000);
        repeat (9) step();
        check("t1_osq2",  32'(occ_pos & 9'h101), fl_hist[1] ? 32'h101 : 32'h000);
        check("t1_xsq2",  32'(occ_pos & 9'h054), 32'h054);

        // Full board, no line
        do_reset();
        mv(0, 4); mv(1, 8); mv(0, 0); mv(1, 3); mv(0, 5); mv(1, 1); mv(0, 7); mv(1, 6);
        check("t2_pre", 32'(game_st), 32'h2D);
        mv(0, 2);
        check("t2_gst", 32'(game_st), 32'h43);

        // Occupied square
        do_reset();
        mv(0, 4);
        press(1'b0, 1'b1, 9'h010, S + 2, 1'b0);
        check("t3_gst", 32'(game_st), 32'h45);
        check("t3_occ", 32'(occ_pos), 32'h010);

        // Wrong player, simultaneous buttons, bad selects
        do_reset();
        press(1'b0, 1'b1, 9'h010, S + 2, 1'b0);
        check("t4_wrong", 32'(game_st), 32'h45);
        do_reset();
        press(1'b1, 1'b1, 9'h010, S + 2, 1'b0);
        check("t4_both", 32'(game_st), 32'h45);
        do_reset();
        press(1'b1, 1'b0, 9'h003, S + 2, 1'b0);
        check("t4_two", 32'(game_st), 32'h45);
        do_reset();
        press(1'b1, 1'b0, 9'h000, S + 2, 1'b0);
        check("t4_none", 32'(game_st), 32'h45);
        check("t4_occ",  32'(occ_pos), 32'h000);

        // Long hold, O pulse lands in CHECK
        do_reset();
        press(1'b1, 1'b0, 9'h010, 20, 1'b1);
        check("t5_turnO", 32'(turnO),   32'h1);
        check("t5_gst",   32'(game_st), 32'h2D);
        check("t5_occ",   32'(occ_pos), 32'h010);
        mv(1, 0);
        check("t5_turnX", 32'(turnX), 32'h1);

        // Reset mid-game and in WIN_O
        do_reset();
        mv(0, 4); mv(1, 0);
        do_reset();
        mv(0, 0); mv(1, 4); mv(0, 1); mv(1, 2); mv(0, 3); mv(1, 6);
        check("t6_wino", 32'(game_st), 32'h4F);
        do_reset();

        for (int g = 0; g < 40; g++) begin
            do_reset();
            for (int n = 0; n < 14; n++) begin
                int         r;
                int         cnt;
                int         pick;
                int         empt [9];
                logic [8:0] sel;
                r   = int'($urandom_range(0, 29));
                cnt = 0;
                for (int i = 0; i < 9; i++)
                    if (!m_x[i] && !m_o[i]) begin
                        empt[cnt] = i;
                        cnt++;
                    end
                if (cnt > 0) begin
                    pick = int'($urandom_range(0, cnt - 1));
                    sel  = 9'(1 << empt[pick]);
                end else begin
                    sel = 9'h001;
                end
                if (r == 0)
                    press(m_to_move == 1, m_to_move == 0, sel, S + 2, 1'b0);
                else if (r == 1)
                    press(1'b1, 1'b1, sel, S + 2, 1'b0);
                else if (r == 2)
                    press(m_to_move == 0, m_to_move == 1, 9'($urandom_range(0, 511)), S + 2, 1'b0);
                else if (r == 3 && (g % 4) == 0)
                    do_reset();
                else
                    press(m_to_move == 0, m_to_move == 1, sel,
                          int'($urandom_range(S + 2, S + 8)), 1'b0);
            end
        end

        step();
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
